// File: rtl/multisim_apb_pkg.sv
// Shared APB types for the multisim capture path: phase-FSM state codes and the
// packed transfer record handed to the transport layer.
package multisim_apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_SETUP  = 4'b0010;
  localparam logic [3:0] ST_ACCESS = 4'b0100;

  typedef enum logic [3:0] {
    APB_IDLE   = ST_IDLE,
    APB_SETUP  = ST_SETUP,
    APB_ACCESS = ST_ACCESS
  } multisim_apb_state_t;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
    logic                  write;
    logic                  slverr;
  } multisim_apb_txn_t;

  function automatic logic is_legal_state(input logic [3:0] s);
    return (s == ST_IDLE) || (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/multisim_sync_fifo.sv
// Generic first-word-fall-through FIFO with an explicit occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module multisim_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; occupancy alone decides what is valid, and the
  // head is forced to zero while empty so stale entries never reach the port.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/multisim_apb_txn_capture.sv
// Captures each completed APB transfer as one record, buffers it, and tracks
// transfers lost to a full buffer plus illegal phase-FSM encodings.
module multisim_apb_txn_capture
  import multisim_apb_pkg::*;
#(
  parameter  int ADDR_W = APB_ADDR_W,
  parameter  int DATA_W = APB_DATA_W,
  parameter  int DEPTH  = 8,
  parameter  int CNT_W  = 16,
  localparam int REC_W  = ADDR_W + DATA_W + 2,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_state,
  input  logic              i_apb_psel,
  input  logic              i_apb_pready,
  input  logic              i_apb_pwrite,
  input  logic [ADDR_W-1:0] i_apb_paddr,
  input  logic [DATA_W-1:0] i_apb_pwdata,
  input  logic [DATA_W-1:0] i_apb_prdata,
  input  logic              i_apb_pslverr,
  output logic              o_txn_valid,
  input  logic              i_txn_ready,
  output logic [REC_W-1:0]  o_txn,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_drop_cnt,
  input  logic              i_clr,
  output logic              o_state_err
);

  logic             r_armed;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_state_err;
  logic             w_capture;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;

  // Arming on SETUP limits each transfer to one record however long ACCESS lingers.
  assign w_capture = r_armed && (i_state == ST_ACCESS) && i_apb_psel && i_apb_pready;
  assign w_pop     = !w_empty && i_txn_ready;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;
  assign w_rec     = {i_apb_paddr, (i_apb_pwrite ? i_apb_pwdata : i_apb_prdata),
                      i_apb_pwrite, i_apb_pslverr};

  multisim_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (o_txn),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_state_err <= 1'b0;
    end else begin
      if (i_state == ST_SETUP) r_armed <= 1'b1;
      else if (w_capture)      r_armed <= 1'b0;

      // Clear wins over the old count, but a same-edge drop still registers.
      if (i_clr) begin
        r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
        r_overflow <= w_drop;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end

      r_state_err <= !is_legal_state(i_state);
    end
  end

  assign o_txn_valid = !w_empty;
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_state_err = r_state_err;

endmodule

// File: tb/tb_multisim_apb_txn_capture.sv
// Self-checking bench: directed APB scenarios plus random traffic, all compared
// against a queue-based transfer model evaluated once per clock edge.
module tb_multisim_apb_txn_capture;
  import multisim_apb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int RW    = AW + DW + 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    i_state;
  logic          i_apb_psel, i_apb_pready, i_apb_pwrite, i_apb_pslverr;
  logic [AW-1:0] i_apb_paddr;
  logic [DW-1:0] i_apb_pwdata, i_apb_prdata;
  logic          o_txn_valid, i_txn_ready, o_overflow, i_clr, o_state_err;
  logic [RW-1:0] o_txn;
  logic [LW-1:0] o_level;
  logic [CNT_W-1:0] o_drop_cnt;
  multisim_apb_txn_t head;

  always #5 clk = ~clk;
  assign head = o_txn;

  multisim_apb_txn_capture #(
    .ADDR_W (AW), .DATA_W (DW), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_state       (i_state),
    .i_apb_psel    (i_apb_psel),
    .i_apb_pready  (i_apb_pready),
    .i_apb_pwrite  (i_apb_pwrite),
    .i_apb_paddr   (i_apb_paddr),
    .i_apb_pwdata  (i_apb_pwdata),
    .i_apb_prdata  (i_apb_prdata),
    .i_apb_pslverr (i_apb_pslverr),
    .o_txn_valid   (o_txn_valid),
    .i_txn_ready   (i_txn_ready),
    .o_txn         (o_txn),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_drop_cnt    (o_drop_cnt),
    .i_clr         (i_clr),
    .o_state_err   (o_state_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending records, arming flag, drop accounting.
  logic [RW-1:0]    m_q[$];
  bit               m_armed;
  bit               m_ovf;
  logic [CNT_W-1:0] m_cnt;
  bit               m_serr;
  bit               rand_ready = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_armed = 1'b0;
    m_ovf   = 1'b0;
    m_cnt   = '0;
    m_serr  = 1'b0;
  endtask

  task automatic compare_all();
    logic [RW-1:0] exp_txn;
    exp_txn = (m_q.size() != 0) ? m_q[0] : '0;
    check("valid",     o_txn_valid, m_q.size() != 0);
    check("txn",       o_txn,       exp_txn);
    check("level",     o_level,     m_q.size());
    check("overflow",  o_overflow,  m_ovf);
    check("drop_cnt",  o_drop_cnt,  m_cnt);
    check("state_err", o_state_err, m_serr);
  endtask

  // Apply the current inputs to the model, let the DUT see one edge, compare.
  task automatic tick();
    bit legal, pop, cap, full, drop;
    if (rand_ready) i_txn_ready = 1'($urandom_range(0, 1));
    legal = (i_state == 4'b0001) || (i_state == 4'b0010) || (i_state == 4'b0100);
    pop   = (m_q.size() != 0) && i_txn_ready;
    cap   = m_armed && (i_state == 4'b0100) && i_apb_psel && i_apb_pready;
    full  = (m_q.size() == DEPTH);
    drop  = cap && full && !pop;
    if (i_state == 4'b0010) m_armed = 1'b1;
    else if (cap)           m_armed = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (cap && !drop)
      m_q.push_back({i_apb_paddr, (i_apb_pwrite ? i_apb_pwdata : i_apb_prdata),
                     i_apb_pwrite, i_apb_pslverr});
    if (i_clr) begin
      m_cnt = drop ? CNT_W'(1) : '0;
      m_ovf = drop;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
    end
    m_serr = !legal;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic go_idle();
    i_state      = 4'b0001;
    i_apb_psel   = 1'b0;
    i_apb_pready = 1'b0;
  endtask

  task automatic apb_txn(input bit w, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input bit err, input int waits, input int hold,
                         input bit pop_on_cap, input bit clr_on_cap);
    i_state       = 4'b0010;
    i_apb_psel    = 1'b1;
    i_apb_pready  = 1'b0;
    i_apb_pwrite  = w;
    i_apb_paddr   = addr;
    i_apb_pwdata  = w ? data : $urandom;
    i_apb_prdata  = w ? $urandom : data;
    i_apb_pslverr = err;
    tick();
    i_state = 4'b0100;
    repeat (waits) tick();
    i_apb_pready = 1'b1;
    if (pop_on_cap) i_txn_ready = 1'b1;
    i_clr = clr_on_cap;
    tick();
    if (pop_on_cap) i_txn_ready = 1'b0;
    i_clr = 1'b0;
    repeat (hold) tick();
    go_idle();
  endtask

  task automatic drain(input int n);
    i_txn_ready = 1'b1;
    repeat (n) tick();
    i_txn_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    go_idle();
    i_apb_pwrite = 1'b0; i_apb_paddr = '0; i_apb_pwdata = '0; i_apb_prdata = '0;
    i_apb_pslverr = 1'b0; i_txn_ready = 1'b0; i_clr = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Write with one wait state.
    apb_txn(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1, 0, 1'b0, 1'b0);
    check("wr_valid", o_txn_valid, 1'b1);
    check("wr_rec",   o_txn, {32'h40, 32'hDEADBEEF, 1'b1, 1'b0});
    drain(2);

    // Read with error, ACCESS held two extra cycles.
    apb_txn(1'b0, 32'h44, 32'h12345678, 1'b1, 0, 2, 1'b0, 1'b0);
    tick();
    check("rd_level", o_level, 1);
    check("rd_rec",   o_txn, {32'h44, 32'h12345678, 1'b0, 1'b1});
    drain(2);

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 10; i++) apb_txn(1'b1, 32'h100 + 4 * i, i, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    check("fill_level", o_level, 8);
    check("fill_drops", o_drop_cnt, 2);
    check("fill_ovf",   o_overflow, 1'b1);
    i_txn_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("fill_order", head.addr, 32'h100 + 4 * k);
      tick();
    end
    i_txn_ready = 1'b0;

    // Full FIFO, capture on the same edge as a pop.
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    for (int i = 0; i < 8; i++) apb_txn(1'b1, 32'h200 + 4 * i, i, 1'b0, 0, 0, 1'b0, 1'b0);
    apb_txn(1'b1, 32'h2F0, 32'hA5A5A5A5, 1'b0, 0, 0, 1'b1, 1'b0);
    tick();
    check("fullpop_level", o_level, 8);
    check("fullpop_drops", o_drop_cnt, 0);
    i_txn_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("fullpop_order", head.addr, (k == 7) ? 32'h2F0 : 32'h204 + 4 * k);
      tick();
    end
    i_txn_ready = 1'b0;

    // Clear coinciding with a drop.
    for (int i = 0; i < 10; i++) apb_txn(1'b1, 32'h300 + 4 * i, i, 1'b0, 0, 0, 1'b0, 1'b0);
    apb_txn(1'b1, 32'h3F0, 32'h1, 1'b0, 0, 0, 1'b0, 1'b1);
    check("clr_drop_cnt", o_drop_cnt, 1);
    check("clr_drop_ovf", o_overflow, 1'b1);
    drain(8);

    // Illegal state encoding while armed.
    i_state = 4'b0010; tick();
    i_state = 4'b1000; i_apb_psel = 1'b1; i_apb_pready = 1'b1; tick();
    check("illegal_err",   o_state_err, 1'b1);
    check("illegal_level", o_level, 0);
    go_idle(); tick();
    check("illegal_pulse", o_state_err, 1'b0);

    // Drop counter saturation.
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    for (int i = 0; i < 25; i++) apb_txn(1'b1, 32'h400 + 4 * i, i, 1'b0, 0, 0, 1'b0, 1'b0);
    check("sat_cnt", o_drop_cnt, {CNT_W{1'b1}});
    drain(8);

    // Reset in the middle of ACCESS.
    for (int i = 0; i < 2; i++) apb_txn(1'b1, 32'h500 + 4 * i, i, 1'b0, 0, 0, 1'b0, 1'b0);
    i_state = 4'b0010; i_apb_psel = 1'b1; tick();
    i_state = 4'b0100; tick();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", o_txn_valid, 1'b0);
    check("rst_txn",   o_txn, '0);
    check("rst_level", o_level, 0);
    check("rst_ovf",   o_overflow, 1'b0);
    check("rst_cnt",   o_drop_cnt, 0);
    check("rst_serr",  o_state_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    i_apb_pready = 1'b1;
    repeat (3) tick();
    check("rst_nocap", o_level, 0);
    go_idle();
    apb_txn(1'b0, 32'h600, 32'hCAFEF00D, 1'b0, 0, 0, 1'b0, 1'b0);
    check("rst_recap", o_level, 1);
    drain(2);

    // Random traffic including illegal states, random ready and clears.
    rand_ready = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      int sel;
      logic [3:0] st;
      sel = $urandom_range(0, 9);
      if (sel < 3)      st = 4'b0001;
      else if (sel < 6) st = 4'b0010;
      else if (sel < 9) st = 4'b0100;
      else begin
        st = 4'($urandom);
        while (st == 4'b0001 || st == 4'b0010 || st == 4'b0100) st = 4'($urandom);
      end
      i_state       = st;
      i_apb_psel    = ($urandom_range(0, 7) != 0);
      i_apb_pready  = 1'($urandom_range(0, 1));
      i_apb_pwrite  = 1'($urandom_range(0, 1));
      i_apb_paddr   = $urandom;
      i_apb_pwdata  = $urandom;
      i_apb_prdata  = $urandom;
      i_apb_pslverr = 1'($urandom_range(0, 1));
      i_clr         = ($urandom_range(0, 29) == 0);
      tick();
    end
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
